vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator: successor to the fixed 640x480 controller.
//  Single clock domain: both axes are counted on vga_clk; no logic is clocked from hsync.
//  Drives hsync/vsync/de and pixel coordinates to the pixel pipeline.
//  Provides a fetch coordinate stream LEAD cycles ahead of de, to hide framebuffer read latency.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (clocks)
//  H_SYNC     96   hsync pulse width (clocks)
//  H_BP       48   horizontal back porch (clocks)
//  V_ACTIVE   480  visible lines
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines)
//  H_POL      0    hsync active level (0 = active-low)
//  V_POL      0    vsync active level (0 = active-low)
//  LEAD       0    fetch lead in clocks; legal range 0..H_TOTAL-1
//  CW         11   counter/coordinate width; 2**CW must be >= H_TOTAL and >= V_TOTAL
// PORTS
//  vga_clk      in   1   pixel clock
//  rst_n        in   1   asynchronous reset, active-low
//  en           in   1   advance enable; 0 freezes the raster
//  posx         out  CW  current pixel column, valid while de=1
//  posy         out  CW  current line, valid while de=1
//  de           out  1   display enable (active region)
//  hsync        out  1   horizontal sync, polarity H_POL
//  vsync        out  1   vertical sync, polarity V_POL
//  line_start   out  1   1-clock pulse coincident with de of pixel (0,y)
//  frame_start  out  1   1-clock pulse coincident with de of pixel (0,0)
//  fetch_valid  out  1   fetch coordinate is inside the active area
//  fetch_x      out  CW  column that de will present LEAD enabled clocks later
//  fetch_y      out  CW  line that de will present LEAD enabled clocks later
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the V_* equivalent.
//  - Internal counters: h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps
//    and wraps 0..V_TOTAL-1. Both advance only when en=1.
//  - Every output is a register decoded from the pre-edge counters: one clock of latency.
//    At the first enabled edge after reset, outputs present (0,0) with de=1, line_start=1 and
//    frame_start=1.
//  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//  - hsync = H_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
//  - vsync = V_POL while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise ~V_POL.
//  - posx/posy load h_cnt/v_cnt when the decode is active. Otherwise they hold their last value.
//  - Fetch coordinates:
//      fh = (h_cnt + LEAD) mod H_TOTAL;
//      fv = v_cnt, plus 1 if h_cnt + LEAD >= H_TOTAL, mod V_TOTAL.
//    fetch_valid = (fh < H_ACTIVE) && (fv < V_ACTIVE). fetch_x and fetch_y are registered like posx/posy.
//    Invariant, for unbroken en=1: fetch_{valid,x,y} at clock t equal de/posx/posy at clock t+LEAD.
//    With LEAD=0 the fetch outputs equal de/posx/posy exactly.
//  - en=0: counters and all outputs hold, except de, line_start, frame_start and fetch_valid,
//    which are forced to 0. On the next en=1 edge the raster resumes with no skipped or repeated pixel.
//  - Reset (async, any time, including mid-frame):
//      counters = 0; posx/posy/fetch_x/fetch_y = 0;
//      de, line_start, frame_start, fetch_valid = 0;
//      hsync = ~H_POL; vsync = ~V_POL.
//  - Arithmetic is unsigned CW-bit. The LEAD sum is computed at CW+1 bits, so it cannot overflow.
//  - Elaboration-time check ($error) if any porch or sync parameter is 0, LEAD >= H_TOTAL,
//    or a total exceeds 2**CW.
// STRUCTURE
//  - Package vga_timing_pkg:
//      mode constant sets (VGA_640x480, SVGA_800x600);
//      H_TOTAL/V_TOTAL helper functions;
//      region enum {ACTIVE, FRONT, SYNC, BACK}.
//  - Sub-module vga_axis_counter (parameters ACTIVE/FP/SYNC/BP/POL/CW).
//    Provides: wrapping counter with inc/wrap outputs, plus combinational region and sync decode.
//    Instantiated twice: horizontal with inc=en; vertical with inc=en & h_wrap.
//  - Fetch-offset adder and output registers live in the top level.
// TESTING
//  - Reset: hold rst_n=0 with the clock running -> hsync=vsync=1, de=0, posx=posy=0.
//    Assert rst_n mid-line with no clock edge -> outputs go to reset values immediately.
//  - Line timing, defaults:
//      de high for exactly 640 clocks; hsync low for 96 clocks;
//      hsync falls 656 clocks after the line_start pulse; line_start period is 800.
//  - Frame timing:
//      vsync low for exactly 2*800 clocks, starting at line 490;
//      frame_start period 420000; exactly 480 line_start pulses per frame.
//  - Enable:
//      drop en for 5 clocks while posx=100 -> de=0 and hsync/posx frozen;
//      re-raise en -> posx=100 is presented, then 101 (no pixel skipped or repeated).
//  - Fetch lead, LEAD=4:
//      fetch_valid rises 4 clocks before de, and fetch_x matches posx 4 clocks later;
//      fetch (0,1) is issued during the last 4 clocks of line 0;
//      fetch (0,0) is issued while v_cnt=524.
//  - Small mode (H 4/1/1/1, V 3/1/1/1, H_POL=V_POL=1):
//      H_TOTAL=7, V_TOTAL=6;
//      sync pulses are active-high, 1 clock / 1 line wide;
//      full-frame scoreboard against a reference model over 3 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Purpose: shared definitions for the raster timing generator.
//   - region_e:      position of a counter inside one axis (active, porches, sync)
//   - mode constants: ready-made timing sets for common display modes
//   - axis_total / h_total / v_total: total length of an axis in clocks or lines
package vga_timing_pkg;

    // Where an axis counter currently sits inside its period
    typedef enum logic [1:0] {
        REGION_ACTIVE = 2'd0,
        REGION_FRONT  = 2'd1,
        REGION_SYNC   = 2'd2,
        REGION_BACK   = 2'd3
    } region_e;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
    localparam int   VGA_640x480_H_ACTIVE  = 640;
    localparam int   VGA_640x480_H_FP      = 16;
    localparam int   VGA_640x480_H_SYNC    = 96;
    localparam int   VGA_640x480_H_BP      = 48;
    localparam int   VGA_640x480_V_ACTIVE  = 480;
    localparam int   VGA_640x480_V_FP      = 10;
    localparam int   VGA_640x480_V_SYNC    = 2;
    localparam int   VGA_640x480_V_BP      = 33;
    localparam logic VGA_640x480_H_POL     = 1'b0;
    localparam logic VGA_640x480_V_POL     = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
    localparam int   SVGA_800x600_H_ACTIVE = 800;
    localparam int   SVGA_800x600_H_FP     = 40;
    localparam int   SVGA_800x600_H_SYNC   = 128;
    localparam int   SVGA_800x600_H_BP     = 88;
    localparam int   SVGA_800x600_V_ACTIVE = 600;
    localparam int   SVGA_800x600_V_FP     = 1;
    localparam int   SVGA_800x600_V_SYNC   = 4;
    localparam int   SVGA_800x600_V_BP     = 23;
    localparam logic SVGA_800x600_H_POL    = 1'b1;
    localparam logic SVGA_800x600_V_POL    = 1'b1;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int h_active, input int h_fp, input int h_sync, input int h_bp);
        return axis_total(h_active, h_fp, h_sync, h_bp);
    endfunction

    function automatic int v_total(input int v_active, input int v_fp, input int v_sync, input int v_bp);
        return axis_total(v_active, v_fp, v_sync, v_bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Module: vga_axis_counter
// Purpose: one raster axis. A counter running 0..TOTAL-1 that advances when
//          inc_i is high and wraps to 0, plus a combinational decode of the
//          current count into its region and the sync level.
// Ports:
//   clk_i     in   pixel clock
//   rst_ni    in   asynchronous reset, active-low (count returns to 0)
//   inc_i     in   advance the count on this edge
//   cnt_o     out  current count (CW bits)
//   wrap_o    out  high when this edge takes the count from TOTAL-1 back to 0
//   region_o  out  region of the current count
//   sync_o    out  POL while in the sync region, ~POL otherwise
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter int   BP     = 48,
    parameter logic POL    = 1'b0,
    parameter int   CW     = 11
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o,
    output region_e       region_o,
    output logic          sync_o
);

    localparam int            TOTAL       = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST_C      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FRONT_START = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START  = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BACK_START  = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] ONE_C       = CW'(1'b1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_s;
    region_e       region_s;
    logic          sync_s;

    // Next count: hold, increment, or wrap at the end of the period
    always_comb begin
        cnt_d  = cnt_q;
        wrap_s = 1'b0;
        if (inc_i) begin
            if (cnt_q == LAST_C) begin
                cnt_d  = '0;
                wrap_s = 1'b1;
            end else begin
                cnt_d  = cnt_q + ONE_C;
                wrap_s = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            wrap_s = 1'b0;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Region decode; the regions are contiguous so ordered compares suffice
    always_comb begin
        region_s = REGION_ACTIVE;
        if (cnt_q < FRONT_START) begin
            region_s = REGION_ACTIVE;
        end else if (cnt_q < SYNC_START) begin
            region_s = REGION_FRONT;
        end else if (cnt_q < BACK_START) begin
            region_s = REGION_SYNC;
        end else begin
            region_s = REGION_BACK;
        end
    end

    // Sync level follows the region
    always_comb begin
        sync_s = ~POL;
        case (region_s)
            REGION_SYNC: sync_s = POL;
            default:     sync_s = ~POL;
        endcase
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = wrap_s;
    assign region_o = region_s;
    assign sync_o   = sync_s;

endmodule

// File: rtl/vga_timing_gen.sv
// Module: vga_timing_gen
// Purpose: parametrised raster timing generator. Horizontal and vertical
//          counters both run on vga_clk; every output is a register decoded
//          from the counters as they stood before the edge, so outputs lag
//          the counters by one clock. A second coordinate stream (fetch_*)
//          runs LEAD enabled clocks ahead of de/posx/posy so a framebuffer
//          read can be launched early.
// Ports:
//   vga_clk      in   pixel clock
//   rst_n        in   asynchronous reset, active-low
//   en           in   advance enable; 0 freezes the raster
//   posx/posy    out  current pixel column/line, valid while de=1
//   de           out  display enable
//   hsync/vsync  out  syncs, active level H_POL/V_POL
//   line_start   out  pulse with de of pixel (0,y)
//   frame_start  out  pulse with de of pixel (0,0)
//   fetch_valid  out  fetch coordinate lies inside the active area
//   fetch_x/y    out  coordinate de will present LEAD enabled clocks later
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   LEAD     = 0,
    parameter int   CW       = 11
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] posx,
    output logic [CW-1:0] posy,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          fetch_valid,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y
);

    localparam int            H_TOTAL    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int            V_TOTAL    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW:0]   LEAD_W     = (CW+1)'(LEAD);
    localparam logic [CW:0]   H_TOTAL_W  = (CW+1)'(H_TOTAL);
    localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE_C      = CW'(1'b1);

    if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if ((LEAD < 0) || (LEAD >= H_TOTAL)) begin : g_bad_lead
        $error("vga_timing_gen: LEAD must lie in 0..H_TOTAL-1");
    end
    if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW))) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for the line or frame total");
    end

    logic [CW-1:0] h_cnt_s;
    logic          h_wrap_s;
    region_e       h_region_s;
    logic          h_sync_s;
    logic [CW-1:0] v_cnt_s;
    logic          v_wrap_unused_s;
    region_e       v_region_s;
    logic          v_sync_s;
    logic          v_inc_s;

    assign v_inc_s = en & h_wrap_s;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .CW     (CW)
    ) u_h_axis (
        .clk_i    (vga_clk),
        .rst_ni   (rst_n),
        .inc_i    (en),
        .cnt_o    (h_cnt_s),
        .wrap_o   (h_wrap_s),
        .region_o (h_region_s),
        .sync_o   (h_sync_s)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .CW     (CW)
    ) u_v_axis (
        .clk_i    (vga_clk),
        .rst_ni   (rst_n),
        .inc_i    (v_inc_s),
        .cnt_o    (v_cnt_s),
        .wrap_o   (v_wrap_unused_s),
        .region_o (v_region_s),
        .sync_o   (v_sync_s)
    );

    logic          de_s;
    logic          line_start_s;
    logic          frame_start_s;
    logic [CW:0]   fsum_s;
    logic [CW-1:0] fh_s;
    logic [CW-1:0] fv_s;
    logic          fvalid_s;

    // Display-region decode of the current counters
    always_comb begin
        de_s          = (h_region_s == REGION_ACTIVE) && (v_region_s == REGION_ACTIVE);
        line_start_s  = de_s && (h_cnt_s == '0);
        frame_start_s = line_start_s && (v_cnt_s == '0);
    end

    // Fetch coordinate: h_cnt+LEAD at CW+1 bits; a carry past the line end
    // moves to the start of the next line (and the next frame after the last line).
    // The true wrapped column is below 2**CW, so subtracting at CW bits is exact.
    always_comb begin
        fsum_s = {1'b0, h_cnt_s} + LEAD_W;
        fh_s   = fsum_s[CW-1:0];
        fv_s   = v_cnt_s;
        if (fsum_s >= H_TOTAL_W) begin
            fh_s = fsum_s[CW-1:0] - H_TOTAL_C;
            if (v_cnt_s == V_LAST_C) begin
                fv_s = '0;
            end else begin
                fv_s = v_cnt_s + ONE_C;
            end
        end else begin
            fh_s = fsum_s[CW-1:0];
            fv_s = v_cnt_s;
        end
        fvalid_s = (fh_s < H_ACTIVE_C) && (fv_s < V_ACTIVE_C);
    end

    logic [CW-1:0] posx_q, posx_d;
    logic [CW-1:0] posy_q, posy_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [CW-1:0] fetch_x_q, fetch_x_d;
    logic [CW-1:0] fetch_y_q, fetch_y_d;

    // Output next-state: with en low the strobes drop and everything else holds
    always_comb begin
        posx_d        = posx_q;
        posy_d        = posy_q;
        de_d          = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_x_d     = fetch_x_q;
        fetch_y_d     = fetch_y_q;
        if (en) begin
            de_d          = de_s;
            hsync_d       = h_sync_s;
            vsync_d       = v_sync_s;
            line_start_d  = line_start_s;
            frame_start_d = frame_start_s;
            fetch_valid_d = fvalid_s;
            if (de_s) begin
                posx_d = h_cnt_s;
                posy_d = v_cnt_s;
            end else begin
                posx_d = posx_q;
                posy_d = posy_q;
            end
            if (fvalid_s) begin
                fetch_x_d = fh_s;
                fetch_y_d = fv_s;
            end else begin
                fetch_x_d = fetch_x_q;
                fetch_y_d = fetch_y_q;
            end
        end else begin
            de_d          = 1'b0;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
            fetch_valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            posx_q        <= '0;
            posy_q        <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
        end else begin
            posx_q        <= posx_d;
            posy_q        <= posy_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
        end
    end

    assign posx        = posx_q;
    assign posy        = posy_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_x     = fetch_x_q;
    assign fetch_y     = fetch_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances share clock and reset:
//   0: default 640x480 timing, LEAD=0
//   1: medium mode H 16/2/3/3, V 6/1/1/2, LEAD=4, vsync active-high
//   2: small mode H 4/1/1/1, V 3/1/1/1, both syncs active-high, LEAD=6 (max)
// Each is compared every clock against a model that derives the expected
// outputs from the number of enabled edges since reset (raster index).
module tb_vga_timing_gen;

    typedef struct {
        logic        de, hs, vs, ls, fs, fv;
        logic [31:0] x, y, fx, fy;
    } out_t;

    typedef struct {
        logic        v;
        logic [31:0] x, y;
    } fq_t;

    int c_ha[3]   = '{640, 16, 4};
    int c_hf[3]   = '{16, 2, 1};
    int c_hs[3]   = '{96, 3, 1};
    int c_hb[3]   = '{48, 3, 1};
    int c_va[3]   = '{480, 6, 3};
    int c_vf[3]   = '{10, 1, 1};
    int c_vs[3]   = '{2, 1, 1};
    int c_vb[3]   = '{33, 2, 1};
    bit c_hp[3]   = '{1'b0, 1'b0, 1'b1};
    bit c_vp[3]   = '{1'b0, 1'b1, 1'b1};
    int c_lead[3] = '{0, 4, 6};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en0, en1, en2;
    logic [10:0] px0, py0, fx0, fy0;
    logic [5:0]  px1, py1, fx1, fy1;
    logic [2:0]  px2, py2, fx2, fy2;
    logic de0, hs0, vs0, ls0, fs0, fv0;
    logic de1, hs1, vs1, ls1, fs1, fv1;
    logic de2, hs2, vs2, ls2, fs2, fv2;

    vga_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                     .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
                     .H_POL(1'b0), .V_POL(1'b0), .LEAD(0), .CW(11)) u_dut0 (
        .vga_clk(clk), .rst_n(rst_n), .en(en0), .posx(px0), .posy(py0), .de(de0),
        .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0),
        .fetch_valid(fv0), .fetch_x(fx0), .fetch_y(fy0));

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(2),
                     .H_POL(1'b0), .V_POL(1'b1), .LEAD(4), .CW(6)) u_dut1 (
        .vga_clk(clk), .rst_n(rst_n), .en(en1), .posx(px1), .posy(py1), .de(de1),
        .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1),
        .fetch_valid(fv1), .fetch_x(fx1), .fetch_y(fy1));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1), .LEAD(6), .CW(3)) u_dut2 (
        .vga_clk(clk), .rst_n(rst_n), .en(en2), .posx(px2), .posy(py2), .de(de2),
        .hsync(hs2), .vsync(vs2), .line_start(ls2), .frame_start(fs2),
        .fetch_valid(fv2), .fetch_x(fx2), .fetch_y(fy2));

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_edges[3];
    out_t exp_s[3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Raster position for a given enabled-edge index, straight from the timing rules
    function automatic out_t decode(input int k, input int idx);
        out_t r;
        int ht, vt, p, h, v;
        ht = c_ha[k] + c_hf[k] + c_hs[k] + c_hb[k];
        vt = c_va[k] + c_vf[k] + c_vs[k] + c_vb[k];
        p  = idx % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        r = '{default: '0};
        r.de = (h < c_ha[k]) && (v < c_va[k]);
        r.hs = ((h >= c_ha[k] + c_hf[k]) && (h < c_ha[k] + c_hf[k] + c_hs[k])) ? c_hp[k] : !c_hp[k];
        r.vs = ((v >= c_va[k] + c_vf[k]) && (v < c_va[k] + c_vf[k] + c_vs[k])) ? c_vp[k] : !c_vp[k];
        r.ls = r.de && (h == 0);
        r.fs = r.ls && (v == 0);
        r.x  = h;
        r.y  = v;
        return r;
    endfunction

    task automatic model_reset(input int k);
        exp_s[k]    = '{default: '0};
        exp_s[k].hs = !c_hp[k];
        exp_s[k].vs = !c_vp[k];
        n_edges[k]  = 0;
    endtask

    task automatic model_step(input int k, input logic e);
        out_t p, q;
        if (e) begin
            p = decode(k, n_edges[k]);
            q = decode(k, n_edges[k] + c_lead[k]);
            exp_s[k].de = p.de;
            exp_s[k].ls = p.ls;
            exp_s[k].fs = p.fs;
            exp_s[k].hs = p.hs;
            exp_s[k].vs = p.vs;
            if (p.de) begin
                exp_s[k].x = p.x;
                exp_s[k].y = p.y;
            end
            exp_s[k].fv = q.de;
            if (q.de) begin
                exp_s[k].fx = q.x;
                exp_s[k].fy = q.y;
            end
            n_edges[k]++;
        end else begin
            exp_s[k].de = 1'b0;
            exp_s[k].ls = 1'b0;
            exp_s[k].fs = 1'b0;
            exp_s[k].fv = 1'b0;
        end
    endtask

    function automatic out_t observe(input int k);
        out_t o;
        o = '{default: '0};
        case (k)
            0: begin
                o.de = de0; o.hs = hs0; o.vs = vs0; o.ls = ls0; o.fs = fs0; o.fv = fv0;
                o.x = 32'(px0); o.y = 32'(py0); o.fx = 32'(fx0); o.fy = 32'(fy0);
            end
            1: begin
                o.de = de1; o.hs = hs1; o.vs = vs1; o.ls = ls1; o.fs = fs1; o.fv = fv1;
                o.x = 32'(px1); o.y = 32'(py1); o.fx = 32'(fx1); o.fy = 32'(fy1);
            end
            default: begin
                o.de = de2; o.hs = hs2; o.vs = vs2; o.ls = ls2; o.fs = fs2; o.fv = fv2;
                o.x = 32'(px2); o.y = 32'(py2); o.fx = 32'(fx2); o.fy = 32'(fy2);
            end
        endcase
        return o;
    endfunction

    task automatic compare_inst(input int k);
        out_t  o;
        string p;
        o = observe(k);
        p = $sformatf("i%0d@%0d", k, cyc);
        check_eq({p, ".de"},    32'(o.de), 32'(exp_s[k].de));
        check_eq({p, ".hsync"}, 32'(o.hs), 32'(exp_s[k].hs));
        check_eq({p, ".vsync"}, 32'(o.vs), 32'(exp_s[k].vs));
        check_eq({p, ".lstart"}, 32'(o.ls), 32'(exp_s[k].ls));
        check_eq({p, ".fstart"}, 32'(o.fs), 32'(exp_s[k].fs));
        check_eq({p, ".fvalid"}, 32'(o.fv), 32'(exp_s[k].fv));
        check_eq({p, ".posx"},  o.x,  exp_s[k].x);
        check_eq({p, ".posy"},  o.y,  exp_s[k].y);
        check_eq({p, ".fetch_x"}, o.fx, exp_s[k].fx);
        check_eq({p, ".fetch_y"}, o.fy, exp_s[k].fy);
    endtask

    // One clock: sample 1 time unit after the edge, advance models, compare
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            model_step(0, en0);
            model_step(1, en1);
            model_step(2, en2);
        end
        for (int k = 0; k < 3; k++) compare_inst(k);
    endtask

    function automatic logic rnd_en();
        return ($urandom_range(0, 99) < 80);
    endfunction

    initial begin
        int   last_ls, ls_period, de_rise, de_len, hs_fall, hs_len, ls_to_hs;
        logic p_de, p_hs, p_de1, p_fv1, found;
        logic hs_frozen;
        logic [10:0] px_frozen;
        int   fv_rise, lead_dist;
        fq_t  fq[$];
        fq_t  f;

        // Reset held with the clock running
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        for (int k = 0; k < 3; k++) model_reset(k);
        for (int i = 0; i < 5; i++) tick();
        check_eq("rst.hsync0", 32'(hs0), 32'd1);
        check_eq("rst.vsync0", 32'(vs0), 32'd1);
        rst_n = 1'b1;

        // Free run: instance 0 unbroken, others random enable; measure line timing
        last_ls = -1; ls_period = -1; de_rise = -1; de_len = -1;
        hs_fall = -1; hs_len = -1; ls_to_hs = -1;
        p_de = 1'b0; p_hs = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            en0 = 1'b1; en1 = rnd_en(); en2 = rnd_en();
            tick();
            if (ls0) begin
                if (last_ls >= 0) ls_period = cyc - last_ls;
                last_ls = cyc;
            end
            if (de0 && !p_de) de_rise = cyc;
            if (!de0 && p_de && (de_rise >= 0)) de_len = cyc - de_rise;
            if (!hs0 && p_hs) begin
                hs_fall = cyc;
                if (last_ls >= 0) ls_to_hs = cyc - last_ls;
            end
            if (hs0 && !p_hs && (hs_fall >= 0)) hs_len = cyc - hs_fall;
            p_de = de0; p_hs = hs0;
        end
        check_eq("line.period",   32'(ls_period), 32'd800);
        check_eq("line.de_len",   32'(de_len),    32'd640);
        check_eq("line.hs_len",   32'(hs_len),    32'd96);
        check_eq("line.ls_to_hs", 32'(ls_to_hs),  32'd656);

        // Enable freeze on instance 0 around column 100
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            en0 = 1'b1; en1 = rnd_en(); en2 = rnd_en();
            tick();
            if (de0 && (px0 == 11'd99)) found = 1'b1;
        end
        check_eq("en.find_col99", 32'(found), 32'd1);
        px_frozen = px0;
        hs_frozen = hs0;
        for (int i = 0; i < 5; i++) begin
            en0 = 1'b0; en1 = rnd_en(); en2 = rnd_en();
            tick();
            check_eq("en.frz_de",   32'(de0), 32'd0);
            check_eq("en.frz_posx", 32'(px0), 32'(px_frozen));
            check_eq("en.frz_hs",   32'(hs0), 32'(hs_frozen));
        end
        en0 = 1'b1;
        tick();
        check_eq("en.resume_de",   32'(de0), 32'd1);
        check_eq("en.resume_x100", 32'(px0), 32'd100);
        tick();
        check_eq("en.resume_x101", 32'(px0), 32'd101);

        // Asynchronous reset between clock edges
        for (int i = 0; i < 7; i++) begin
            en1 = rnd_en(); en2 = rnd_en();
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            compare_inst(k);
        end
        check_eq("arst.de0",   32'(de0), 32'd0);
        check_eq("arst.posx0", 32'(px0), 32'd0);
        check_eq("arst.hs0",   32'(hs0), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;

        // Instance 1 with unbroken enable: fetch leads de by exactly LEAD clocks
        en0 = 1'b1; en1 = 1'b1;
        fv_rise = -1; lead_dist = -1;
        p_de1 = de1; p_fv1 = fv1;
        for (int i = 0; i < 600; i++) begin
            en2 = rnd_en();
            tick();
            fq.push_back('{v: fv1, x: 32'(fx1), y: 32'(fy1)});
            if (fq.size() > 4) begin
                f = fq.pop_front();
                check_eq("lead.inv_valid", 32'(de1), 32'(f.v));
                if (f.v) begin
                    check_eq("lead.inv_x", 32'(px1), f.x);
                    check_eq("lead.inv_y", 32'(py1), f.y);
                end
            end
            if (fv1 && !p_fv1) fv_rise = cyc;
            if ((i >= 48) && de1 && !p_de1 && (fv_rise >= 0)) lead_dist = cyc - fv_rise;
            p_de1 = de1; p_fv1 = fv1;
        end
        check_eq("lead.rise_dist", 32'(lead_dist), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
